// File: rtl/arm_pkg.sv
// Shared types for the ARM pipeline hazard unit: scoreboard entries,
// the E-stage operand select encoding and the forwarding priority rule.
package arm_pkg;

  localparam int unsigned ARM_REG_ADDR_W     = 4;
  localparam int unsigned ARM_PC_REG         = 15;
  // Scoreboard register fields are held at this width; narrower indices are zero-extended.
  localparam int unsigned ARM_MAX_REG_ADDR_W = 8;

  typedef logic [ARM_MAX_REG_ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t ra1;
    reg_idx_t ra2;
    logic     use1;
    logic     use2;
    reg_idx_t wa;
    logic     regwrite;
    logic     memtoreg;
    logic     pcwrite;
  } hazard_entry_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t wa;
    logic     regwrite;
    logic     memtoreg;
    logic     pcwrite;
  } stage_entry_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // M is younger than W, so it wins when both hold the requested register.
  function automatic fwd_sel_t fwd_select(input stage_entry_t m, input stage_entry_t w,
                                          input reg_idx_t ra);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (m.valid && m.regwrite && !m.memtoreg && (m.wa == ra)) begin
      sel = FWD_M;
    end else if (w.valid && w.regwrite && (w.wa == ra)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/arm_hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones; synchronous clear beats increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/arm_hazard_unit.sv
// Hazard, forwarding and stall/flush control for the 5-stage ARM pipeline.
// Tracks E/M/W in a private scoreboard and counts stall and flush cycles.
module arm_hazard_unit
  import arm_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = ARM_REG_ADDR_W,
  parameter int unsigned PC_REG     = ARM_PC_REG,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d_valid,
  input  logic [REG_ADDR_W-1:0] d_ra1,
  input  logic [REG_ADDR_W-1:0] d_ra2,
  input  logic                  d_use1,
  input  logic                  d_use2,
  input  logic [REG_ADDR_W-1:0] d_wa,
  input  logic                  d_regwrite,
  input  logic                  d_memtoreg,
  input  logic                  d_pcwrite,
  input  logic                  e_cond_ok,
  input  logic                  e_branch_taken,
  input  logic                  cnt_clr,
  output logic [1:0]            fwd_ae,
  output logic [1:0]            fwd_be,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam reg_idx_t PcIdx = reg_idx_t'(PC_REG);

  hazard_entry_t e_q, e_d;
  stage_entry_t  m_q, m_d;
  stage_entry_t  w_q, w_d;

  reg_idx_t d_ra1_w, d_ra2_w, d_wa_w;
  logic     ldrstall, pcwp, w_pcsrc, stall_ev;
  fwd_sel_t fwd_a, fwd_b;
  logic     unused_w_memtoreg;

  assign d_ra1_w = reg_idx_t'(d_ra1);
  assign d_ra2_w = reg_idx_t'(d_ra2);
  assign d_wa_w  = reg_idx_t'(d_wa);

  // A taken branch squashes the dependent instruction anyway, so it suppresses the load-use stall.
  assign ldrstall = e_q.valid & e_q.memtoreg & e_q.regwrite & d_valid
                  & ((d_use1 & (d_ra1_w == e_q.wa)) | (d_use2 & (d_ra2_w == e_q.wa)))
                  & ~e_branch_taken;
  assign pcwp     = (d_valid & d_pcwrite) | (e_q.valid & e_q.pcwrite) | (m_q.valid & m_q.pcwrite);
  assign w_pcsrc  = w_q.valid & w_q.pcwrite;

  assign stall_f  = ldrstall | pcwp;
  assign stall_d  = ldrstall;
  assign flush_d  = pcwp | w_pcsrc | e_branch_taken;
  assign flush_e  = ldrstall | e_branch_taken;
  assign stall_ev = ldrstall | pcwp;

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (e_q.use1 && (e_q.ra1 != PcIdx)) begin
      fwd_a = fwd_select(m_q, w_q, e_q.ra1);
    end
    if (e_q.use2 && (e_q.ra2 != PcIdx)) begin
      fwd_b = fwd_select(m_q, w_q, e_q.ra2);
    end
  end

  assign fwd_ae = fwd_a;
  assign fwd_be = fwd_b;

  always_comb begin
    w_d          = m_q;
    m_d.valid    = e_q.valid;
    m_d.wa       = e_q.wa;
    m_d.regwrite = e_q.regwrite & e_cond_ok;
    m_d.memtoreg = e_q.memtoreg;
    m_d.pcwrite  = e_q.pcwrite & e_cond_ok;
    e_d          = '0;
    if (!flush_e) begin
      e_d.valid    = d_valid;
      e_d.ra1      = d_ra1_w;
      e_d.ra2      = d_ra2_w;
      e_d.use1     = d_use1;
      e_d.use2     = d_use2;
      e_d.wa       = d_wa_w;
      e_d.regwrite = d_regwrite;
      e_d.memtoreg = d_memtoreg;
      e_d.pcwrite  = d_pcwrite;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign unused_w_memtoreg = w_q.memtoreg;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .inc_i  (stall_ev),
    .clr_i  (cnt_clr),
    .cnt_o  (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .inc_i  (e_branch_taken),
    .clr_i  (cnt_clr),
    .cnt_o  (flush_cnt)
  );

endmodule

// File: tb/tb_arm_hazard_unit.sv
// Bench for arm_hazard_unit: directed pipeline scenarios plus randomized
// traffic compared against an instruction-level pipeline model.
module tb_arm_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       d_valid, d_use1, d_use2, d_regwrite, d_memtoreg, d_pcwrite;
  logic [3:0] d_ra1, d_ra2, d_wa;
  logic       e_cond_ok, e_branch_taken, cnt_clr;

  logic [1:0]  fwd_ae, fwd_be, fwd_ae2, fwd_be2;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic        stall_f2, stall_d2, flush_d2, flush_e2;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  stall_cnt2, flush_cnt2;

  arm_hazard_unit dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_ra1(d_ra1), .d_ra2(d_ra2),
    .d_use1(d_use1), .d_use2(d_use2), .d_wa(d_wa), .d_regwrite(d_regwrite),
    .d_memtoreg(d_memtoreg), .d_pcwrite(d_pcwrite), .e_cond_ok(e_cond_ok),
    .e_branch_taken(e_branch_taken), .cnt_clr(cnt_clr), .fwd_ae(fwd_ae), .fwd_be(fwd_be),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  arm_hazard_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_ra1(d_ra1), .d_ra2(d_ra2),
    .d_use1(d_use1), .d_use2(d_use2), .d_wa(d_wa), .d_regwrite(d_regwrite),
    .d_memtoreg(d_memtoreg), .d_pcwrite(d_pcwrite), .e_cond_ok(e_cond_ok),
    .e_branch_taken(e_branch_taken), .cnt_clr(cnt_clr), .fwd_ae(fwd_ae2), .fwd_be(fwd_be2),
    .stall_f(stall_f2), .stall_d(stall_d2), .flush_d(flush_d2), .flush_e(flush_e2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  // Instruction-level model: pipe[0]=E, pipe[1]=M, pipe[2]=W.
  typedef struct packed {
    bit       v;
    bit [3:0] ra1;
    bit [3:0] ra2;
    bit       u1;
    bit       u2;
    bit [3:0] wa;
    bit       rw;
    bit       mt;
    bit       pw;
  } ins_t;

  ins_t        pipe [3];
  int unsigned m_scnt, m_fcnt, m_scnt2, m_fcnt2;
  int          asserts  = 0;
  int          failures = 0;

  function automatic bit m_ldr();
    return pipe[0].v && pipe[0].mt && pipe[0].rw && d_valid &&
           ((d_use1 && d_ra1 == pipe[0].wa) || (d_use2 && d_ra2 == pipe[0].wa)) &&
           !e_branch_taken;
  endfunction

  function automatic bit m_pcwp();
    return (d_valid && d_pcwrite) || (pipe[0].v && pipe[0].pw) || (pipe[1].v && pipe[1].pw);
  endfunction

  function automatic logic [1:0] m_fwd(input bit [3:0] ra, input bit u);
    if (!u || ra == 4'd15) return 2'b00;
    if (pipe[1].v && pipe[1].rw && !pipe[1].mt && pipe[1].wa == ra) return 2'b10;
    if (pipe[2].v && pipe[2].rw && pipe[2].wa == ra) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] m_ctrl();
    bit l, p;
    l = m_ldr();
    p = m_pcwp();
    return {l || p, l, p || (pipe[2].v && pipe[2].pw) || e_branch_taken, l || e_branch_taken};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_scnt = 0; m_fcnt = 0; m_scnt2 = 0; m_fcnt2 = 0;
  endtask

  task automatic model_advance();
    bit l, p;
    l = m_ldr();
    p = m_pcwp();
    if (cnt_clr) begin
      m_scnt = 0; m_fcnt = 0; m_scnt2 = 0; m_fcnt2 = 0;
    end else begin
      if (l || p) begin
        if (m_scnt < 65535) m_scnt++;
        if (m_scnt2 < 3) m_scnt2++;
      end
      if (e_branch_taken) begin
        if (m_fcnt < 65535) m_fcnt++;
        if (m_fcnt2 < 3) m_fcnt2++;
      end
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[1].rw = pipe[0].rw && e_cond_ok;
    pipe[1].pw = pipe[0].pw && e_cond_ok;
    pipe[1].ra1 = '0; pipe[1].ra2 = '0; pipe[1].u1 = 0; pipe[1].u2 = 0;
    pipe[0] = '0;
    if (!(l || e_branch_taken)) begin
      pipe[0].v = d_valid;   pipe[0].ra1 = d_ra1; pipe[0].ra2 = d_ra2;
      pipe[0].u1 = d_use1;   pipe[0].u2 = d_use2; pipe[0].wa = d_wa;
      pipe[0].rw = d_regwrite; pipe[0].mt = d_memtoreg; pipe[0].pw = d_pcwrite;
    end
  endtask

  task automatic tick();
    if (!reset) model_reset();
    else model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int ra1, input bit u1, input int ra2, input bit u2,
                       input int wa, input bit rw, input bit mt, input bit pw);
    d_valid = v; d_ra1 = 4'(ra1); d_use1 = u1; d_ra2 = 4'(ra2); d_use2 = u2;
    d_wa = 4'(wa); d_regwrite = rw; d_memtoreg = mt; d_pcwrite = pw;
  endtask

  task automatic bubble();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    bubble();
    e_branch_taken = 0;
    e_cond_ok = 1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 1, 15, 1, 0, 1);
    tick();
    bubble();
    #2;
    asserts++;
    if (stall_cnt !== 16'd1) begin
      failures++; $display("FAIL pre_reset_cnt got %0d exp 1", stall_cnt);
    end
    reset = 0;
    #1;
    asserts++;
    if ({fwd_ae, fwd_be, stall_f, stall_d, flush_d, flush_e} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got %b exp 00000000", {fwd_ae, fwd_be, stall_f, stall_d, flush_d, flush_e});
    end
    asserts++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || stall_cnt2 !== 2'd0) begin
      failures++; $display("FAIL reset_cnt got %0d/%0d/%0d exp 0", stall_cnt, flush_cnt, stall_cnt2);
    end
    tick();
    tick();
    reset = 1;
  endtask

  task automatic test_back_to_back();
    drain();
    drive(1, 2, 1, 3, 1, 1, 1, 0, 0); #2; tick();   // ADD R1,R2,R3
    drive(1, 1, 1, 3, 1, 2, 1, 0, 0); #2; tick();   // SUB R2,R1,R3
    drive(1, 1, 1, 2, 1, 6, 1, 0, 0); #2;           // ORR R6,R1,R2
    asserts++;
    if (fwd_ae !== 2'b10 || fwd_be !== 2'b00) begin
      failures++; $display("FAIL b2b_fwd_m got %b/%b exp 10/00", fwd_ae, fwd_be);
    end
    tick();
    bubble(); #2;
    asserts++;
    if (fwd_ae !== 2'b01 || fwd_be !== 2'b10) begin
      failures++; $display("FAIL b2b_fwd_w got %b/%b exp 01/10", fwd_ae, fwd_be);
    end
    drain();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0); tick();
    drive(1, 7, 1, 7, 1, 8, 1, 0, 0); tick();
    bubble(); #2;
    asserts++;
    if (fwd_ae !== 2'b10 || fwd_be !== 2'b10) begin
      failures++; $display("FAIL fwd_conflict got %b/%b exp 10/10", fwd_ae, fwd_be);
    end
    drain();
    drive(1, 0, 0, 0, 0, 15, 1, 0, 0); tick();
    drive(1, 15, 1, 3, 0, 9, 1, 0, 0); tick();
    bubble(); #2;
    asserts++;
    if (fwd_ae !== 2'b00) begin
      failures++; $display("FAIL fwd_pc_src got %b exp 00", fwd_ae);
    end
  endtask

  task automatic test_load_use();
    drain();
    cnt_clr = 1; tick(); cnt_clr = 0;
    drive(1, 0, 1, 0, 0, 4, 1, 1, 0); #2; tick();   // LDR R4,[R0]
    drive(1, 4, 1, 4, 1, 5, 1, 0, 0); #2;           // ADD R5,R4,R4
    asserts++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1101) begin
      failures++; $display("FAIL ldr_stall got %b exp 1101", {stall_f, stall_d, flush_d, flush_e});
    end
    tick(); #2;
    asserts++;
    if ({stall_f, stall_d, flush_e} !== 3'b000 || stall_cnt !== 16'd1) begin
      failures++; $display("FAIL ldr_one_cycle got %b cnt %0d exp 000 cnt 1", {stall_f, stall_d, flush_e}, stall_cnt);
    end
    tick();
    bubble(); #2;
    asserts++;
    if (fwd_ae !== 2'b01 || fwd_be !== 2'b01) begin
      failures++; $display("FAIL ldr_fwd_w got %b/%b exp 01/01", fwd_ae, fwd_be);
    end
  endtask

  task automatic test_pc_write();
    for (int c = 1; c >= 0; c--) begin
      int sf, fd;
      drain();
      e_cond_ok = (c == 1);
      drive(1, 0, 0, 0, 1, 15, 1, 0, 1);            // MOV PC,R0
      sf = 0; fd = 0;
      for (int i = 0; i < 6; i++) begin
        #2;
        sf += int'(stall_f);
        fd += int'(flush_d);
        tick();
        if (i == 0) bubble();
      end
      asserts++;
      if (sf != (c == 1 ? 3 : 2) || fd != (c == 1 ? 4 : 2)) begin
        failures++; $display("FAIL pc_write cond=%0d got stall %0d flush %0d exp %0d/%0d",
                             c, sf, fd, (c == 1 ? 3 : 2), (c == 1 ? 4 : 2));
      end
    end
    e_cond_ok = 1;
  endtask

  task automatic test_branch_vs_loaduse();
    logic [15:0] base;
    drain();
    drive(1, 0, 1, 0, 0, 4, 1, 1, 0); #2; tick();
    drive(1, 4, 1, 0, 0, 5, 1, 0, 0);
    e_branch_taken = 1;
    #2;
    asserts++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011) begin
      failures++; $display("FAIL branch_wins got %b exp 0011", {stall_f, stall_d, flush_d, flush_e});
    end
    base = flush_cnt;
    tick();
    e_branch_taken = 0;
    bubble(); #2;
    asserts++;
    if (flush_cnt !== base + 16'd1) begin
      failures++; $display("FAIL branch_flush_cnt got %0d exp %0d", flush_cnt, base + 16'd1);
    end
  endtask

  task automatic test_counter_sat();
    drain();
    cnt_clr = 1; tick(); cnt_clr = 0;
    drive(1, 0, 0, 0, 0, 15, 1, 0, 1);
    repeat (5) tick();
    bubble(); #2;
    asserts++;
    if (stall_cnt2 !== 2'd3 || stall_cnt !== 16'd5) begin
      failures++; $display("FAIL cnt_saturate got %0d/%0d exp 3/5", stall_cnt2, stall_cnt);
    end
    cnt_clr = 1; tick(); cnt_clr = 0; #2;
    asserts++;
    if (stall_cnt2 !== 2'd0 || stall_cnt !== 16'd0) begin
      failures++; $display("FAIL cnt_clear got %0d/%0d exp 0/0", stall_cnt2, stall_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    drive(1, 0, 1, 0, 0, 4, 1, 1, 0); #2; tick();
    drive(1, 4, 1, 0, 0, 5, 1, 0, 0); #2;
    asserts++;
    if (stall_d !== 1'b1) begin
      failures++; $display("FAIL mid_stall_setup got %b exp 1", stall_d);
    end
    reset = 0;
    #1;
    asserts++;
    if ({stall_f, stall_d, flush_e} !== 3'b000 || stall_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_mid_stall got %b cnt %0d exp 000 cnt 0", {stall_f, stall_d, flush_e}, stall_cnt);
    end
    tick();
    reset = 1;
    bubble();
  endtask

  task automatic test_random();
    logic [3:0] ec;
    int r;
    drain();
    for (int n = 0; n < 400; n++) begin
      d_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 4); d_ra1 = (r == 4) ? 4'd15 : 4'(r);
      r = $urandom_range(0, 4); d_ra2 = (r == 4) ? 4'd15 : 4'(r);
      r = $urandom_range(0, 4); d_wa  = (r == 4) ? 4'd15 : 4'(r);
      d_use1 = 1'($urandom_range(0, 1));
      d_use2 = 1'($urandom_range(0, 1));
      d_regwrite = ($urandom_range(0, 3) != 0);
      d_memtoreg = ($urandom_range(0, 2) == 0);
      d_pcwrite  = ($urandom_range(0, 9) == 0);
      e_cond_ok  = ($urandom_range(0, 3) != 0);
      e_branch_taken = ($urandom_range(0, 9) == 0);
      cnt_clr    = ($urandom_range(0, 59) == 0);
      #2;
      ec = m_ctrl();
      asserts++;
      if ({stall_f, stall_d, flush_d, flush_e} !== ec) begin
        failures++; $display("FAIL rand_ctrl n=%0d got %b exp %b", n, {stall_f, stall_d, flush_d, flush_e}, ec);
      end
      asserts++;
      if (fwd_ae !== m_fwd(pipe[0].ra1, pipe[0].u1) || fwd_be !== m_fwd(pipe[0].ra2, pipe[0].u2)) begin
        failures++; $display("FAIL rand_fwd n=%0d got %b/%b exp %b/%b", n, fwd_ae, fwd_be,
                             m_fwd(pipe[0].ra1, pipe[0].u1), m_fwd(pipe[0].ra2, pipe[0].u2));
      end
      asserts++;
      if (stall_cnt !== 16'(m_scnt) || flush_cnt !== 16'(m_fcnt)) begin
        failures++; $display("FAIL rand_cnt n=%0d got %0d/%0d exp %0d/%0d", n, stall_cnt, flush_cnt, m_scnt, m_fcnt);
      end
      asserts++;
      if (stall_cnt2 !== 2'(m_scnt2) || flush_cnt2 !== 2'(m_fcnt2)
          || {stall_f2, stall_d2, flush_d2, flush_e2} !== ec) begin
        failures++; $display("FAIL rand_sat n=%0d got %0d/%0d exp %0d/%0d", n, stall_cnt2, flush_cnt2, m_scnt2, m_fcnt2);
      end
      tick();
    end
    cnt_clr = 0;
    drain();
  endtask

  initial begin
    reset = 0;
    bubble();
    e_cond_ok = 1;
    e_branch_taken = 0;
    cnt_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_pc_write();
    test_branch_vs_loaduse();
    test_counter_sat();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
